// File: rtl/ab_stim_gen.sv
// ab_stim_gen -- pseudo-random two-bit stimulus generator.
//
// On a start request seen in IDLE the block spends two SETTLE cycles with
// a=b=0, then drives NUM_VEC vectors {a,b} taken from a 16-bit Galois LFSR.
// Each vector is held for a number of cycles. It then pulses done for one
// cycle and returns to IDLE. The LFSR is never reloaded between runs, so
// consecutive runs continue one long sequence. Only reset restarts it from
// SEED.
//
// Optional feature macro: AB_STIM_HOLD_RAND_EN
//   defined   : hold = MIN_HOLD + (lfsr[15:8] % (MAX_HOLD-MIN_HOLD+1)),
//               computed from the LFSR value before it advances
//   undefined : hold = MIN_HOLD for every vector (MAX_HOLD is not used)
//
// Parameters
//   NUM_VEC   vectors per run, 1..255
//   MIN_HOLD  minimum hold cycles, >= 1
//   MAX_HOLD  maximum hold cycles, MIN_HOLD..255
//   SEED      initial LFSR value (0 is replaced by 16'hACE1)
//
// Ports
//   clk        in   rising-edge clock
//   res        in   asynchronous active-high reset
//   start      in   run request, sampled only in IDLE
//   a, b       out  registered stimulus pair
//   busy       out  high in SETTLE, RUN and DONE
//   done       out  one-cycle pulse at the end of a run
//   vec_cnt    out  1-based index of the current vector, 0 when idle
//   state_dbg  out  current FSM state (0 IDLE, 1 SETTLE, 2 RUN, 3 DONE)
//
// Handshake: start is a level request with no ready. A request is accepted
// on any rising edge where the FSM is in IDLE and start=1. busy rises on
// that same edge, and start is ignored until busy has dropped again.
module ab_stim_gen #(
  parameter int          NUM_VEC  = 20,
  parameter int          MIN_HOLD = 1,
  parameter int          MAX_HOLD = 4,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic [7:0] vec_cnt,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, DONE} state_t;

  localparam logic [15:0] LFSR_INIT  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [7:0]  LAST_VEC   = 8'(NUM_VEC);

  // Reject configurations outside the supported ranges at elaboration.
  if (NUM_VEC < 1 || NUM_VEC > 255 || MIN_HOLD < 1 ||
      MAX_HOLD < MIN_HOLD || MAX_HOLD > 255) begin : g_bad_cfg
    $error("ab_stim_gen: parameter out of range");
  end

  state_t      state_q, state_d;
  logic        a_q, a_d, b_q, b_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] lfsr_next;
  logic [7:0]  hold_m1;

  // Galois step: shift right, fold the taps in when a 1 falls out.
  assign lfsr_next = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ 16'hB400)
                               : {1'b0, lfsr_q[15:1]};

  // Hold counter load value (hold-1), derived from the pre-advance LFSR.
`ifdef AB_STIM_HOLD_RAND_EN
  localparam int HOLD_RANGE = MAX_HOLD - MIN_HOLD + 1;
  logic [7:0] hold_sel;
  assign hold_sel = 8'(MIN_HOLD) + 8'({24'd0, lfsr_q[15:8]} % HOLD_RANGE);
  assign hold_m1  = hold_sel - 8'd1;
`else
  assign hold_m1  = 8'(MIN_HOLD - 1);
`endif

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 8'd0;
      hold_q  <= 8'd0;
      lfsr_q  <= LFSR_INIT;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      lfsr_q  <= lfsr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    lfsr_d  = lfsr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          busy_d  = 1'b1;
          a_d     = 1'b0;
          b_d     = 1'b0;
          cnt_d   = 8'd0;
          // The hold counter doubles as the settle timer: 1 -> 0 -> leave.
          hold_d  = 8'd1;
        end
      end
      SETTLE: begin
        if (hold_q != 8'd0) begin
          hold_d = hold_q - 8'd1;
        end else begin
          state_d    = RUN;
          {a_d, b_d} = lfsr_q[1:0];
          cnt_d      = 8'd1;
          hold_d     = hold_m1;
          lfsr_d     = lfsr_next;
        end
      end
      RUN: begin
        if (hold_q != 8'd0) begin
          hold_d = hold_q - 8'd1;
        end else if (cnt_q != LAST_VEC) begin
          {a_d, b_d} = lfsr_q[1:0];
          cnt_d      = cnt_q + 8'd1;
          hold_d     = hold_m1;
          lfsr_d     = lfsr_next;
        end else begin
          state_d = DONE;
          a_d     = 1'b0;
          b_d     = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = 8'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign vec_cnt   = cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ab_stim_gen.sv
// Bench for ab_stim_gen. Five instances with different parameter sets share
// clk and res. A per-instance reference model is built from the LFSR rule
// and the run rules to produce the expected cycle-by-cycle trace of
// {busy, done, a, b, vec_cnt}.
module tb_ab_stim_gen;

  localparam int NDUT = 5;
  //                                 dut0      dut1      dut2      dut3      dut4
  localparam int          P_NUM [NDUT] = '{20,       3,        1,        20,       200};
  localparam int          P_MIN [NDUT] = '{1,        2,        1,        1,        1};
  localparam int          P_MAX [NDUT] = '{4,        4,        1,        4,        4};
  localparam logic [15:0] P_SEED[NDUT] = '{16'hACE1, 16'h0001, 16'hACE1, 16'h0000, 16'h1234};

  logic clk = 1'b0;
  logic res = 1'b1;
  logic [NDUT-1:0] start_v = '0;
  logic [NDUT-1:0] a_v, b_v, busy_v, done_v;
  logic [NDUT-1:0][7:0] cnt_v;
  logic [NDUT-1:0][1:0] st_v;

  int errors = 0;
  int checks = 0;
  logic [15:0] mlfsr[NDUT];
  logic [4:0] seen_hold = '0;

  always #5 clk = ~clk;

  ab_stim_gen #(.NUM_VEC(P_NUM[0]), .MIN_HOLD(P_MIN[0]), .MAX_HOLD(P_MAX[0]), .SEED(P_SEED[0])) u_dut0 (
    .clk(clk), .res(res), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .vec_cnt(cnt_v[0]), .state_dbg(st_v[0]));
  ab_stim_gen #(.NUM_VEC(P_NUM[1]), .MIN_HOLD(P_MIN[1]), .MAX_HOLD(P_MAX[1]), .SEED(P_SEED[1])) u_dut1 (
    .clk(clk), .res(res), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .vec_cnt(cnt_v[1]), .state_dbg(st_v[1]));
  ab_stim_gen #(.NUM_VEC(P_NUM[2]), .MIN_HOLD(P_MIN[2]), .MAX_HOLD(P_MAX[2]), .SEED(P_SEED[2])) u_dut2 (
    .clk(clk), .res(res), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .vec_cnt(cnt_v[2]), .state_dbg(st_v[2]));
  ab_stim_gen #(.NUM_VEC(P_NUM[3]), .MIN_HOLD(P_MIN[3]), .MAX_HOLD(P_MAX[3]), .SEED(P_SEED[3])) u_dut3 (
    .clk(clk), .res(res), .start(start_v[3]), .a(a_v[3]), .b(b_v[3]), .busy(busy_v[3]),
    .done(done_v[3]), .vec_cnt(cnt_v[3]), .state_dbg(st_v[3]));
  ab_stim_gen #(.NUM_VEC(P_NUM[4]), .MIN_HOLD(P_MIN[4]), .MAX_HOLD(P_MAX[4]), .SEED(P_SEED[4])) u_dut4 (
    .clk(clk), .res(res), .start(start_v[4]), .a(a_v[4]), .b(b_v[4]), .busy(busy_v[4]),
    .done(done_v[4]), .vec_cnt(cnt_v[4]), .state_dbg(st_v[4]));

  // ---------------- reference model ----------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic int model_hold(input int d, input logic [15:0] s);
`ifdef AB_STIM_HOLD_RAND_EN
    return P_MIN[d] + (int'(s[15:8]) % (P_MAX[d] - P_MIN[d] + 1));
`else
    return P_MIN[d];
`endif
  endfunction

  function automatic logic [11:0] pack_obs(input int d);
    return {busy_v[d], done_v[d], a_v[d], b_v[d], cnt_v[d]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++)
      mlfsr[d] = (P_SEED[d] == 16'h0000) ? 16'hACE1 : P_SEED[d];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full run of instance d. start is held for start_len edges; after
  // that, if rand_start is set, start toggles randomly while busy and must
  // be ignored. The run ends with one cycle back in IDLE.
  task automatic do_run(input int d, input int start_len, input bit rand_start);
    logic [11:0] exp_q[$];
    logic [11:0] obs, e;
    int len[256];
    int n, prev_cnt, h, ok;
    logic [1:0] v;
    foreach (len[k]) len[k] = 0;
    exp_q = {};
    repeat (2) exp_q.push_back({1'b1, 1'b0, 2'b00, 8'd0});
    for (int i = 1; i <= P_NUM[d]; i++) begin
      v = mlfsr[d][1:0];
      h = model_hold(d, mlfsr[d]);
      mlfsr[d] = lfsr_step(mlfsr[d]);
      repeat (h) exp_q.push_back({1'b1, 1'b0, v, 8'(i)});
    end
    exp_q.push_back({1'b1, 1'b1, 2'b00, 8'(P_NUM[d])});
    exp_q.push_back({1'b0, 1'b0, 2'b00, 8'd0});
    n = exp_q.size();

    @(negedge clk);
    start_v[d] = 1'b1;
    prev_cnt = 0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      obs = pack_obs(d);
      e   = exp_q.pop_front();
      chk($sformatf("dut%0d_cyc%0d", d, j), 32'(obs), 32'(e));
      if (obs[11] && !obs[10] && obs[7:0] != 8'd0) begin
        len[obs[7:0]]++;
        if (int'(obs[7:0]) != prev_cnt) begin
          chk($sformatf("dut%0d_cnt_step", d), 32'(obs[7:0]), 32'(prev_cnt + 1));
          prev_cnt = int'(obs[7:0]);
        end
      end
      if (j + 1 < start_len)             start_v[d] = 1'b1;
      else if (j < n - 1 && rand_start)  start_v[d] = 1'($urandom_range(0, 1));
      else                               start_v[d] = 1'b0;
    end
    chk($sformatf("dut%0d_last_cnt", d), 32'(prev_cnt), 32'(P_NUM[d]));
    for (int k = 1; k <= P_NUM[d]; k++) begin
      ok = (len[k] >= P_MIN[d] && len[k] <= P_MAX[d]) ? 1 : 0;
      if (ok == 0) chk($sformatf("dut%0d_hold_vec%0d", d, k), 32'(len[k]), 32'(P_MIN[d]));
      if (d == 4 && len[k] >= 1 && len[k] <= 4) seen_hold[len[k]] = 1'b1;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int found;
    model_reset();

    // reset state, while res is high
    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) chk($sformatf("reset_dut%0d", d), 32'(pack_obs(d)), 32'd0);
    res = 1'b0;

    // documented example: SEED=1, MIN_HOLD=2, NUM_VEC=3 -> 01,00,00 x2
    do_run(1, 1, 1'b0);
    // single vector, single cycle: done 3 cycles after the start edge
    do_run(2, 1, 1'b0);
    // two back-to-back runs: the second continues the LFSR sequence
    do_run(0, 1, 1'b0);
    do_run(0, 1, 1'b1);
    // SEED=0 behaves like SEED=16'hACE1
    do_run(3, 1, 1'b0);

    // long run with start held 50 cycles: exactly one run
    do_run(4, 50, 1'b0);
`ifdef AB_STIM_HOLD_RAND_EN
    chk("dut4_all_holds_seen", 32'(seen_hold[4:1]), 32'hF);
`endif
    repeat (5) begin
      @(negedge clk);
      chk("dut4_stays_idle", 32'(pack_obs(4)), 32'd0);
    end
    // a fresh start in IDLE launches a second run
    do_run(4, 1, 1'b1);

    // asynchronous reset mid-run at vec_cnt=5
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      if (cnt_v[0] == 8'd5) found = 1;
      else @(negedge clk);
    end
    chk("reach_vec5", 32'(found), 32'd1);
    #2 res = 1'b1;
    #1 chk("async_reset_outputs", 32'(pack_obs(0)), 32'd0);
    @(posedge clk);
    #1 chk("no_done_in_reset", 32'(done_v[0]), 32'd0);
    @(negedge clk);
    res = 1'b0;
    model_reset();
    // after reset the sequence restarts from SEED
    do_run(0, 1, 1'b0);
    do_run(3, 1, 1'b0);

    // randomized runs with random idle gaps and random start activity
    for (int r = 0; r < 8; r++) begin
      int d, gap;
      d   = $urandom_range(0, 3);
      gap = $urandom_range(0, 4);
      repeat (gap) begin
        @(negedge clk);
        chk($sformatf("gap_idle_dut%0d", d), 32'(pack_obs(d)), 32'd0);
      end
      do_run(d, 1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
